// File: rtl/reg_file_ldsb.sv
// reg_file_ldsb: register file with two combinational read ports, an ALU
// write-back port and a scoreboarded load write-back port. One outstanding
// load is tracked. Its destination register reads as busy until the data
// returns, or until a younger ALU write to that register supersedes it.
//
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle write
// data (ALU first, then returning load data) onto the read ports.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no load outstanding, new load may be issued
// PENDING  | load outstanding, its data will be written to PA
// SQUASHED | load outstanding but superseded; its data will be dropped
module reg_file_ldsb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  output logic                  OUT1BUSY,
  output logic                  OUT2BUSY,
  input  logic                  LDISSUE,
  input  logic [ADDR_WIDTH-1:0] LDADDRESS,
  output logic                  LDREADY,
  input  logic                  LDDONE,
  input  logic [DATA_WIDTH-1:0] LDDATA
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PENDING  = 2'd1;
  localparam logic [1:0] ST_SQUASHED = 2'd2;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pa_q, pa_d;

  logic alu_hits_pa;
  logic ld_commit;

  // An ALU write to the pending register is younger than the load, so it
  // wins both when it lands alongside LDDONE and when it lands before it.
  assign alu_hits_pa = WRITE && (INADDRESS == pa_q);
  assign ld_commit   = (state_q == ST_PENDING) && LDDONE && !alu_hits_pa;

  // Load tracking next state and pending-address capture
  always_comb begin
    state_d = state_q;
    pa_d    = pa_q;
    case (state_q)
      ST_IDLE: begin
        if (LDISSUE) begin
          state_d = ST_PENDING;
          pa_d    = LDADDRESS;
        end
      end
      ST_PENDING: begin
        if (LDDONE) begin
          state_d = ST_IDLE;
        end else if (alu_hits_pa) begin
          state_d = ST_SQUASHED;
        end
      end
      ST_SQUASHED: begin
        if (LDDONE) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Load tracking state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      pa_q    <= '0;
    end else begin
      state_q <= state_d;
      pa_q    <= pa_d;
    end
  end

  // Register storage: ALU write-back and committed load write-back
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (ld_commit) begin
        regs_q[pa_q] <= LDDATA;
      end
      if (WRITE) begin
        regs_q[INADDRESS] <= IN;
      end
    end
  end

  assign LDREADY = (state_q == ST_IDLE);

`ifdef REG_FILE_BYPASS_EN
  logic ld_fwd;
  assign ld_fwd = (state_q == ST_PENDING) && LDDONE;

  // Read ports with same-cycle forwarding; ALU data takes priority
  always_comb begin
    OUT1     = regs_q[OUT1ADDRESS];
    OUT2     = regs_q[OUT2ADDRESS];
    OUT1BUSY = (state_q == ST_PENDING) && (OUT1ADDRESS == pa_q);
    OUT2BUSY = (state_q == ST_PENDING) && (OUT2ADDRESS == pa_q);
    if (WRITE && (OUT1ADDRESS == INADDRESS)) begin
      OUT1     = IN;
      OUT1BUSY = 1'b0;
    end else if (ld_fwd && (OUT1ADDRESS == pa_q)) begin
      OUT1     = LDDATA;
      OUT1BUSY = 1'b0;
    end
    if (WRITE && (OUT2ADDRESS == INADDRESS)) begin
      OUT2     = IN;
      OUT2BUSY = 1'b0;
    end else if (ld_fwd && (OUT2ADDRESS == pa_q)) begin
      OUT2     = LDDATA;
      OUT2BUSY = 1'b0;
    end
  end
`else
  // Read ports show stored contents only
  always_comb begin
    OUT1     = regs_q[OUT1ADDRESS];
    OUT2     = regs_q[OUT2ADDRESS];
    OUT1BUSY = (state_q == ST_PENDING) && (OUT1ADDRESS == pa_q);
    OUT2BUSY = (state_q == ST_PENDING) && (OUT2ADDRESS == pa_q);
  end
`endif

endmodule

// File: tb/tb_reg_file_ldsb.sv
// tb_reg_file_ldsb: directed test-plan steps followed by random traffic,
// checked against a behavioural model of the register file and load tracker.
module tb_reg_file_ldsb;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int N  = 2 ** AW;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [DW-1:0] IN, LDDATA;
  logic [AW-1:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS, LDADDRESS;
  logic          WRITE, LDISSUE, LDDONE;
  logic [DW-1:0] OUT1, OUT2;
  logic          OUT1BUSY, OUT2BUSY, LDREADY;

  reg_file_ldsb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN(IN), .INADDRESS(INADDRESS),
    .WRITE(WRITE), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(OUT1), .OUT2(OUT2), .OUT1BUSY(OUT1BUSY), .OUT2BUSY(OUT2BUSY),
    .LDISSUE(LDISSUE), .LDADDRESS(LDADDRESS), .LDREADY(LDREADY),
    .LDDONE(LDDONE), .LDDATA(LDDATA)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: memory contents plus an outstanding load that is
  // either live (its data will land) or dead (superseded by an ALU write).
  logic [DW-1:0] mem [N];
  bit            outstanding;
  bit            live;
  logic [AW-1:0] pa;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mem[i] = '0;
    outstanding = 0;
    live        = 0;
    pa          = '0;
  endtask

  // Applies one rising edge worth of behaviour using the currently driven inputs.
  task automatic model_edge();
    if (outstanding) begin
      if (LDDONE) begin
        if (live) mem[pa] = LDDATA;
        outstanding = 0;
        live        = 0;
      end else if (live && WRITE && INADDRESS == pa) begin
        live = 0;
      end
    end else if (LDISSUE) begin
      outstanding = 1;
      live        = 1;
      pa          = LDADDRESS;
    end
    // The ALU write is younger than any load, so it lands last.
    if (WRITE) mem[INADDRESS] = IN;
  endtask

  task automatic exp_port(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic b);
    d = mem[a];
    b = outstanding && live && (a == pa);
`ifdef REG_FILE_BYPASS_EN
    if (WRITE && a == INADDRESS) begin
      d = IN;
      b = 0;
    end else if (outstanding && live && LDDONE && a == pa) begin
      d = LDDATA;
      b = 0;
    end
`endif
  endtask

  task automatic check_all(string tag);
    logic [DW-1:0] d1, d2;
    logic          b1, b2;
    exp_port(OUT1ADDRESS, d1, b1);
    exp_port(OUT2ADDRESS, d2, b2);
    chk({tag, ".OUT1"},     {24'd0, OUT1},     {24'd0, d1});
    chk({tag, ".OUT2"},     {24'd0, OUT2},     {24'd0, d2});
    chk({tag, ".OUT1BUSY"}, {31'd0, OUT1BUSY}, {31'd0, b1});
    chk({tag, ".OUT2BUSY"}, {31'd0, OUT2BUSY}, {31'd0, b2});
    chk({tag, ".LDREADY"},  {31'd0, LDREADY},  {31'd0, !outstanding});
  endtask

  task automatic tick(string tag);
    @(posedge CLK);
    model_edge();
    #3;
    check_all(tag);
  endtask

  task automatic quiet();
    WRITE   = 0;
    LDISSUE = 0;
    LDDONE  = 0;
  endtask

  initial begin
    RESET_N = 1; IN = '0; LDDATA = '0; INADDRESS = '0; LDADDRESS = '0;
    OUT1ADDRESS = '0; OUT2ADDRESS = '0;
    quiet();
    #2 RESET_N = 0;
    model_reset();
    #2 check_all("reset_init");
    #4 RESET_N = 1;

    // Reset mid-cycle wipes a written register without any clock edge
    WRITE = 1; INADDRESS = 3; IN = 8'hAA;
    tick("wr_r3");
    quiet();
    OUT1ADDRESS = 3;
    #2 check_all("rd_r3");
    @(negedge CLK);
    RESET_N = 0;
    model_reset();
    #2 check_all("reset_mid");
    #1 RESET_N = 1;

    // Basic writes and reads
    WRITE = 1; INADDRESS = 5; IN = 8'h3C;
    tick("wr_r5");
    INADDRESS = 6; IN = 8'hC3;
    tick("wr_r6");
    quiet();
    OUT1ADDRESS = 5; OUT2ADDRESS = 6;
    #2 check_all("rd_r5_r6");

    // Plain load with a few cycles of latency
    LDISSUE = 1; LDADDRESS = 2;
    tick("ld_issue_r2");
    quiet();
    OUT1ADDRESS = 2;
    for (int i = 0; i < 4; i++) tick("ld_wait_r2");
    LDDONE = 1; LDDATA = 8'h5A;
    tick("ld_done_r2");
    quiet();
    #2 check_all("ld_after_r2");

    // Squash: younger ALU write supersedes the outstanding load
    LDISSUE = 1; LDADDRESS = 4;
    tick("sq_issue_r4");
    quiet();
    OUT1ADDRESS = 4;
    WRITE = 1; INADDRESS = 4; IN = 8'h11;
    tick("sq_write_r4");
    quiet();
    tick("sq_wait");
    LDDONE = 1; LDDATA = 8'h99;
    tick("sq_done");
    quiet();
    #2 check_all("sq_after");

    // Collision: same-edge ALU write and load return; issue while busy ignored
    LDISSUE = 1; LDADDRESS = 1;
    tick("col_issue_r1");
    LDADDRESS = 6;
    tick("col_reissue_ignored");
    quiet();
    OUT1ADDRESS = 6; OUT2ADDRESS = 1;
    #2 check_all("col_pa_kept");
    WRITE = 1; INADDRESS = 1; IN = 8'h22; LDDONE = 1; LDDATA = 8'h77;
    tick("col_same_addr");
    quiet();

    // Load return and ALU write to different registers, one-cycle latency
    LDISSUE = 1; LDADDRESS = 0;
    tick("diff_issue_r0");
    quiet();
    OUT1ADDRESS = 0; OUT2ADDRESS = 7;
    WRITE = 1; INADDRESS = 7; IN = 8'h0F; LDDONE = 1; LDDATA = 8'hE1;
    tick("diff_both");
    quiet();

    // Issue and ALU write to the same register at one edge: load stays live
    LDISSUE = 1; LDADDRESS = 3; WRITE = 1; INADDRESS = 3; IN = 8'h44;
    OUT1ADDRESS = 3;
    tick("iss_wr_same");
    quiet();
    tick("iss_wr_wait");
    LDDONE = 1; LDDATA = 8'h55;
    tick("iss_wr_done");
    quiet();

    // Pre-edge view of a pending write (forwarded only with bypass)
    WRITE = 1; INADDRESS = 7; IN = 8'hF0; OUT1ADDRESS = 7;
    @(negedge CLK);
    check_all("byp_pre_edge");
    tick("byp_edge");
    quiet();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      WRITE       = ($urandom_range(0, 2) == 0);
      INADDRESS   = AW'($urandom);
      IN          = DW'($urandom);
      LDISSUE     = ($urandom_range(0, 3) == 0);
      LDADDRESS   = AW'($urandom);
      LDDONE      = ($urandom_range(0, 3) == 0);
      LDDATA      = DW'($urandom);
      OUT1ADDRESS = AW'($urandom);
      OUT2ADDRESS = outstanding && ($urandom_range(0, 1) == 1) ? pa : AW'($urandom);
      #1 check_all("rnd_pre");
      if (i == 300) begin
        @(negedge CLK);
        RESET_N = 0;
        model_reset();
        #2 check_all("rnd_reset");
        #1 RESET_N = 1;
      end
      tick("rnd");
    end
    quiet();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
